magic_seq: RTL and testbench
============================

MAGIC_SEQ -- requirements
Module: magic_seq

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, giving the number of program slots.
REQ-002 The module SHALL have parameter NCELL, default 64, giving the number of crossbar cells; cell address width AW = clog2(NCELL) = 6 bits.
REQ-003 CLOCK  input  1  single clock; all state changes on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 PROG_WE  input  1  program write strobe.
REQ-006 PROG_ADDR  input  6  program slot index.
REQ-007 PROG_DATA  input  19  program word {OPNOR[18], SRCA[17:12], SRCB[11:6], DST[5:0]}; OPNOR=1 means NOR(SRCA,SRCB), OPNOR=0 means NOT(SRCA).
REQ-008 START  input  1  run request.
REQ-009 OP_COUNT  input  7  number of ops to run, 0..64.
REQ-010 XBAR_READY  input  1  crossbar accepts the presented command this cycle.
REQ-011 CMD_VALID  output  1  command presented.
REQ-012 CMD_INIT  output  1  1 = initialise DST to logic 1; 0 = evaluate.
REQ-013 CMD_NOR  output  1  evaluate type (1 = NOR, 0 = NOT).
REQ-014 CMD_SRC_A, CMD_SRC_B, CMD_DST  output  6 each  cell addresses.
REQ-015 BUSY  output  1  run in progress.
REQ-016 DONE  output  1  one-cycle run-complete pulse.
REQ-017 ERR  output  1  sticky illegal-op flag.
REQ-018 PC  output  6  index of the current op.

Function
REQ-019 The program store SHALL be a DEPTH x 19 register array written on PROG_WE while in IDLE or DONE; writes in INIT or EVAL SHALL be ignored.
REQ-020 The FSM SHALL have the states IDLE, INIT, EVAL and DONE.
REQ-021 In IDLE with START=1 and OP_COUNT>0, the FSM SHALL latch OP_COUNT, set PC=0, clear ERR and go to INIT.
REQ-022 In IDLE with START=1 and OP_COUNT=0, the FSM SHALL go to DONE without issuing any command.
REQ-023 In INIT, the FSM SHALL drive CMD_VALID=1, CMD_INIT=1 and CMD_DST from slot PC.
REQ-024 In INIT, on transfer (CMD_VALID & XBAR_READY), the FSM SHALL go to EVAL.
REQ-025 In EVAL, the FSM SHALL drive CMD_VALID=1, CMD_INIT=0, and CMD_NOR/SRC_A/SRC_B/DST from slot PC.
REQ-026 In EVAL, on transfer with PC=count-1, the FSM SHALL go to DONE; otherwise it SHALL increment PC and go to INIT.
REQ-027 While XBAR_READY=0, all CMD_* outputs and the state SHALL hold unchanged.
REQ-028 In INIT, if slot PC has DST=SRCA, or OPNOR=1 and DST=SRCB, the FSM SHALL set ERR=1, drive CMD_VALID=0 and go to DONE; no further commands SHALL issue.
REQ-029 DONE SHALL last exactly one cycle with DONE=1, then return to IDLE.
REQ-030 BUSY SHALL equal 1 exactly in INIT and EVAL.
REQ-031 START SHALL be ignored outside IDLE.
REQ-032 With XBAR_READY held at 1, a run of N ops SHALL present 2N commands in consecutive cycles, starting the cycle after START is sampled, with DONE in cycle 2N+1.
REQ-033 When CMD_INIT=1 or CMD_NOR=0, unused CMD_SRC_* fields SHALL be driven 0.
REQ-034 ERR SHALL hold its value until the next accepted START or RESET.

Reset
REQ-035 While RESET=1, state SHALL be IDLE, and PC, CMD_*, BUSY, DONE and ERR SHALL all be 0.
REQ-036 Program store contents SHALL be left undefined by reset.
REQ-037 Reset asserted mid-run SHALL abort immediately, with no DONE pulse.

Verification
REQ-038 Load slot0 NOT(3)->7 and slot1 NOR(7,2)->9, START with OP_COUNT=2, XBAR_READY=1 -> commands INIT dst7, EVAL NOT a3 dst7, INIT dst9, EVAL NOR a7 b2 dst9 in 4 cycles; DONE in cycle 5; ERR=0.
REQ-039 Same program with XBAR_READY=0 for 3 cycles during the first EVAL -> EVAL a3 dst7 held steady for 4 cycles; total 8 cycles to DONE.
REQ-040 START with OP_COUNT=0 -> no CMD_VALID; DONE=1 one cycle after START; BUSY stays 0.
REQ-041 Slot1 = NOR(5,9)->9 with OP_COUNT=3 -> ops 0 complete, ERR=1 and DONE at PC=1, no command for slot1 or slot2.
REQ-042 RESET during EVAL of op 10 of 64 -> outputs 0 next cycle, no DONE; a new START runs from PC=0.
REQ-043 PROG_WE to slot0 while BUSY, and START while BUSY -> both ignored; the run completes with the original slot0 contents.

Source files
------------

// File: rtl/magic_seq.sv
// rtl/magic_seq.sv - program-store sequencer issuing INIT/EVAL command pairs to a NOR crossbar
module magic_seq #(
    parameter  int DEPTH = 64,
    parameter  int NCELL = 64,
    localparam int AW    = $clog2(NCELL),
    localparam int PW    = $clog2(DEPTH),
    localparam int WW    = 1 + 3 * AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          prog_we_i,
    input  logic [PW-1:0] prog_addr_i,
    input  logic [WW-1:0] prog_data_i,
    input  logic          start_i,
    input  logic [PW:0]   op_count_i,
    input  logic          xbar_ready_i,
    output logic          cmd_valid_o,
    output logic          cmd_init_o,
    output logic          cmd_nor_o,
    output logic [AW-1:0] cmd_src_a_o,
    output logic [AW-1:0] cmd_src_b_o,
    output logic [AW-1:0] cmd_dst_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [PW-1:0] pc_o
);
    typedef enum logic [1:0] {S_IDLE, S_INIT, S_EVAL, S_DONE} state_t;

    localparam logic [PW:0] MAX_COUNT = (PW + 1)'(DEPTH);

    state_t        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [PW:0]   count_q, count_d;
    logic          err_q, err_d;

    logic [WW-1:0] prog_mem [DEPTH];
    logic [WW-1:0] word;
    logic          w_nor;
    logic [AW-1:0] w_a, w_b, w_d;
    logic          illegal;

    // Store is frozen during a run so the presented command cannot change under a stall.
    always_ff @(posedge clk_i) begin
        if (prog_we_i && (state_q == S_IDLE || state_q == S_DONE)) begin
            prog_mem[prog_addr_i] <= prog_data_i;
        end
    end

    assign word    = prog_mem[pc_q];
    assign w_nor   = word[WW-1];
    assign w_a     = word[3*AW-1:2*AW];
    assign w_b     = word[2*AW-1:AW];
    assign w_d     = word[AW-1:0];
    // Initialising DST would destroy an operand the evaluate step still needs.
    assign illegal = (w_d == w_a) || (w_nor && (w_d == w_b));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        err_d       = err_q;
        cmd_valid_o = 1'b0;
        cmd_init_o  = 1'b0;
        cmd_nor_o   = 1'b0;
        cmd_src_a_o = '0;
        cmd_src_b_o = '0;
        cmd_dst_o   = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    pc_d  = '0;
                    if (op_count_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        count_d = (op_count_i > MAX_COUNT) ? MAX_COUNT : op_count_i;
                        state_d = S_INIT;
                    end
                end
            end
            S_INIT: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cmd_valid_o = 1'b1;
                    cmd_init_o  = 1'b1;
                    cmd_dst_o   = w_d;
                    if (xbar_ready_i) begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                cmd_valid_o = 1'b1;
                cmd_nor_o   = w_nor;
                cmd_src_a_o = w_a;
                cmd_src_b_o = w_nor ? w_b : '0;
                cmd_dst_o   = w_d;
                if (xbar_ready_i) begin
                    if ({1'b0, pc_q} == count_q - (PW + 1)'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_INIT;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o = (state_q == S_INIT) || (state_q == S_EVAL);
    assign done_o = (state_q == S_DONE);
    assign err_o  = err_q;
    assign pc_o   = pc_q;
endmodule

// File: tb/tb_magic_seq.sv
// tb/tb_magic_seq.sv - self-checking bench for magic_seq against a command-stream model
module tb_magic_seq;
    logic        clk = 1'b0;
    logic        rst_i, prog_we_i, start_i, xbar_ready_i;
    logic [5:0]  prog_addr_i;
    logic [18:0] prog_data_i;
    logic [6:0]  op_count_i;
    logic        cmd_valid_o, cmd_init_o, cmd_nor_o, busy_o, done_o, err_o;
    logic [5:0]  cmd_src_a_o, cmd_src_b_o, cmd_dst_o, pc_o;

    always #5 clk = ~clk;

    magic_seq dut (
        .clk_i(clk), .rst_i(rst_i), .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i),
        .prog_data_i(prog_data_i), .start_i(start_i), .op_count_i(op_count_i),
        .xbar_ready_i(xbar_ready_i), .cmd_valid_o(cmd_valid_o), .cmd_init_o(cmd_init_o),
        .cmd_nor_o(cmd_nor_o), .cmd_src_a_o(cmd_src_a_o), .cmd_src_b_o(cmd_src_b_o),
        .cmd_dst_o(cmd_dst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .pc_o(pc_o)
    );

    typedef struct packed {
        logic       init;
        logic       nor_op;
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] d;
    } cmd_t;

    cmd_t        exp_q[$];
    bit          exp_err;
    logic [18:0] shadow [64];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] op(input bit n, input int a, input int b, input int d);
        return {n, a[5:0], b[5:0], d[5:0]};
    endfunction

    task automatic load(input int addr, input logic [18:0] w);
        prog_we_i   = 1'b1;
        prog_addr_i = addr[5:0];
        prog_data_i = w;
        cyc();
        prog_we_i   = 1'b0;
        shadow[addr] = w;
    endtask

    // Expected transfer stream: each legal op is an INIT then an EVAL; an illegal op ends the run.
    task automatic build(input int n);
        logic [18:0] w;
        exp_q.delete();
        exp_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = shadow[i];
            if (w[5:0] == w[17:12] || (w[18] && w[5:0] == w[11:6])) begin
                exp_err = 1'b1;
                break;
            end
            exp_q.push_back({1'b1, 1'b0, 6'd0, 6'd0, w[5:0]});
            exp_q.push_back({1'b0, w[18], w[17:12], w[18] ? w[11:6] : 6'd0, w[5:0]});
        end
    endtask

    always @(negedge clk) begin : cmp
        cmd_t got;
        if (!rst_i) begin
            if (cmd_valid_o) begin
                got = {cmd_init_o, cmd_nor_o, cmd_src_a_o, cmd_src_b_o, cmd_dst_o};
                if (exp_q.size() == 0) begin
                    chk("extra_cmd", {31'd0, cmd_valid_o}, 0);
                end else begin
                    chk("cmd", {12'd0, got}, {12'd0, exp_q[0]});
                    if (xbar_ready_i) void'(exp_q.pop_front());
                end
            end
            if (done_o) begin
                chk("done_left", exp_q.size(), 0);
                chk("done_err", {31'd0, err_o}, {31'd0, exp_err});
            end
        end
    end

    task automatic run(input int n, input int st_at, input int st_len, input bit choppy,
                       input bit meddle, input int exp_done);
        int k;
        start_i      = 1'b1;
        op_count_i   = n[6:0];
        xbar_ready_i = 1'b1;
        cyc();
        start_i = 1'b0;
        k = 1;
        while (!done_o && k < 1000) begin
            if (n > 0) chk("busy", {31'd0, busy_o}, 1);
            if (k == 1) chk("pc_start", {26'd0, pc_o}, 0);
            xbar_ready_i = !((k >= st_at && k < st_at + st_len) || (choppy && k % 3 == 0));
            if (meddle && k == 1) begin
                prog_we_i   = 1'b1;
                prog_addr_i = 6'd0;
                prog_data_i = op(1, 1, 2, 3);
                start_i     = 1'b1;
                op_count_i  = 7'd5;
            end
            if (meddle && k == 2) begin
                prog_we_i = 1'b0;
                start_i   = 1'b0;
            end
            cyc();
            k++;
        end
        chk("timeout", {31'd0, done_o}, 1);
        if (exp_done > 0) chk("done_cycle", k, exp_done);
        chk("busy_at_done", {31'd0, busy_o}, 0);
        xbar_ready_i = 1'b1;
        prog_we_i    = 1'b0;
        start_i      = 1'b0;
    endtask

    task automatic after_done();
        cyc();
        chk("done_pulse", {31'd0, done_o}, 0);
        chk("idle_busy", {31'd0, busy_o}, 0);
    endtask

    function automatic logic [29:0] all_outs();
        return {cmd_valid_o, cmd_init_o, cmd_nor_o, cmd_src_a_o, cmd_src_b_o, cmd_dst_o,
                busy_o, done_o, err_o, pc_o};
    endfunction

    initial begin
        rst_i = 1'b1; prog_we_i = 1'b0; start_i = 1'b0; xbar_ready_i = 1'b1;
        prog_addr_i = '0; prog_data_i = '0; op_count_i = '0;
        cyc();
        cyc();
        chk("reset_outs", {2'd0, all_outs()}, 0);
        rst_i = 1'b0;
        cyc();

        load(0, op(0, 3, 0, 7));
        load(1, op(1, 7, 2, 9));
        build(2);
        chk("mdl_len", exp_q.size(), 4);
        chk("mdl_c1", {12'd0, exp_q[1]}, {12'd0, 1'b0, 1'b0, 6'd3, 6'd0, 6'd7});
        chk("mdl_c3", {12'd0, exp_q[3]}, {12'd0, 1'b0, 1'b1, 6'd7, 6'd2, 6'd9});
        run(2, 0, 0, 1'b0, 1'b0, 5);
        after_done();

        build(2);
        run(2, 2, 3, 1'b0, 1'b0, 8);
        after_done();

        build(0);
        run(0, 0, 0, 1'b0, 1'b0, 1);
        after_done();

        load(1, op(1, 5, 9, 9));
        load(2, op(0, 1, 0, 2));
        build(3);
        chk("mdl_err", {31'd0, exp_err}, 1);
        chk("mdl_err_len", exp_q.size(), 2);
        run(3, 0, 0, 1'b0, 1'b0, 4);
        chk("err_pc", {26'd0, pc_o}, 1);
        chk("err_flag", {31'd0, err_o}, 1);
        after_done();
        chk("err_sticky", {31'd0, err_o}, 1);

        load(1, op(1, 7, 2, 9));
        build(2);
        run(2, 0, 0, 1'b0, 1'b1, 5);
        chk("err_cleared", {31'd0, err_o}, 0);
        after_done();
        build(2);
        run(2, 0, 0, 1'b0, 1'b0, 5);
        after_done();

        for (int i = 0; i < 64; i++) load(i, op(1, i, (i + 1) % 64, (i + 2) % 64));
        build(64);
        start_i = 1'b1; op_count_i = 7'd64; xbar_ready_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int i = 0; i < 21; i++) cyc();
        chk("abort_pc", {26'd0, pc_o}, 10);
        chk("abort_eval", {30'd0, cmd_valid_o, cmd_init_o}, 2);
        rst_i = 1'b1;
        #1;
        chk("abort_async", {2'd0, all_outs()}, 0);
        cyc();
        chk("abort_held", {2'd0, all_outs()}, 0);
        rst_i = 1'b0;
        exp_q.delete();
        cyc();
        chk("abort_nodone", {31'd0, done_o}, 0);
        build(64);
        run(64, 0, 0, 1'b0, 1'b0, 129);
        after_done();

        build(4);
        run(4, 0, 0, 1'b1, 1'b0, 12);
        after_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
